// File: rtl/bp_lce_busy_ctrl.sv
// bp_lce_busy_ctrl
// ----------------
// Busy/timeout controller for the LCE. It watches the LCE-to-cache packet
// ports and counts how long a port stays blocked (valid without yumi). The
// count is kept either per port or as one aggregate counter. When a counter
// reaches the runtime stall limit, the controller raises cache_req_busy_o. It
// keeps busy high while the contention lasts, and then for a short hold window
// afterwards, so that the LCE gets a free cycle on the contended array.
//
// Ports:
//   clk_i             clock
//   reset_n_i         asynchronous active-low reset
//   pkt_v_i           [num_ports_p]   LCE packet valid, per port
//   pkt_yumi_i        [num_ports_p]   cache accepts packet, per port
//   per_port_mode_i   1 = independent counters, 0 = aggregate (counter 0)
//   timeout_limit_i   [lg_lim_lp]     stall limit, 0 disables, clamped to max
//   credits_full_i    request credits exhausted
//   cmd_ready_i       command module ready
//   req_ready_i       request module ready
//   events_clear_i    synchronous clear of the timeout-event counter
//   cache_req_busy_o  blocks new cache requests
//   timeout_o         some counter equals the effective limit this cycle
//   blocked_mask_o    [num_ports_p]   ports at the limit, latched on STALL entry
//   timeout_events_o  [event_cnt_width_p] saturating count of STALL entries
module bp_lce_busy_ctrl #(
  parameter int num_ports_p         = 3,
  parameter int timeout_max_limit_p = 4,
  parameter int hold_cycles_p       = 2,
  parameter int event_cnt_width_p   = 16,
  localparam int lg_lim_lp = ((timeout_max_limit_p + 1) > 1) ? $clog2(timeout_max_limit_p + 1) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [num_ports_p-1:0]       pkt_v_i,
  input  logic [num_ports_p-1:0]       pkt_yumi_i,
  input  logic                         per_port_mode_i,
  input  logic [lg_lim_lp-1:0]         timeout_limit_i,
  input  logic                         credits_full_i,
  input  logic                         cmd_ready_i,
  input  logic                         req_ready_i,
  input  logic                         events_clear_i,
  output logic                         cache_req_busy_o,
  output logic                         timeout_o,
  output logic [num_ports_p-1:0]       blocked_mask_o,
  output logic [event_cnt_width_p-1:0] timeout_events_o
);

  localparam logic [lg_lim_lp-1:0] max_lim_lp = lg_lim_lp'(timeout_max_limit_p);
  localparam int hold_w_lp = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
  // When hold_cycles_p is 0 the HOLD state is unreachable, so the load value is unused.
  localparam logic [hold_w_lp-1:0] hold_load_lp =
    (hold_cycles_p > 0) ? hold_w_lp'(hold_cycles_p - 1) : {hold_w_lp{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e                                     state_r, state_next_s;
  logic [hold_w_lp-1:0]                       hold_r, hold_next_s;
  logic [num_ports_p-1:0][lg_lim_lp-1:0]      cnt_r, cnt_next_s;
  logic [num_ports_p-1:0]                     mask_r, mask_next_s;
  logic [event_cnt_width_p-1:0]               events_r, events_next_s;

  logic [num_ports_p-1:0] blocked_s;
  logic                   any_blocked_s;
  logic [lg_lim_lp-1:0]   lim_s;
  logic [num_ports_p-1:0] at_lim_s;
  logic                   timeout_s;
  logic                   enter_stall_s;
  logic                   enter_idle_s;

  // Saturating increment of a stall counter. The counter stops at the maximum limit.
  function automatic logic [lg_lim_lp-1:0] sat_inc(input logic [lg_lim_lp-1:0] c);
    return (c >= max_lim_lp) ? max_lim_lp : (c + lg_lim_lp'(1));
  endfunction

  assign blocked_s     = pkt_v_i & ~pkt_yumi_i;
  assign any_blocked_s = |blocked_s;
  assign lim_s         = (timeout_limit_i > max_lim_lp) ? max_lim_lp : timeout_limit_i;

  // Compare the registered counters against the effective limit. A limit change acts immediately.
  always_comb begin
    at_lim_s = {num_ports_p{1'b0}};
    for (int i = 0; i < num_ports_p; i++) begin
      at_lim_s[i] = (cnt_r[i] == lim_s);
    end
  end

  assign timeout_s = (lim_s != {lg_lim_lp{1'b0}}) & (|at_lim_s);

  // Compute the next counter values. In aggregate mode only counter 0 runs, and the others are held at 0.
  always_comb begin
    cnt_next_s = cnt_r;
    for (int i = 0; i < num_ports_p; i++) begin
      if (per_port_mode_i) begin
        cnt_next_s[i] = blocked_s[i] ? sat_inc(cnt_r[i]) : {lg_lim_lp{1'b0}};
      end else if (i == 0) begin
        cnt_next_s[i] = any_blocked_s ? sat_inc(cnt_r[i]) : {lg_lim_lp{1'b0}};
      end else begin
        cnt_next_s[i] = {lg_lim_lp{1'b0}};
      end
    end
  end

  // Next state for the FSM. A timeout during HOLD takes priority over the hold countdown.
  always_comb begin
    state_next_s  = state_r;
    hold_next_s   = hold_r;
    enter_stall_s = 1'b0;
    enter_idle_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (timeout_s) begin
          state_next_s  = STALL;
          enter_stall_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      STALL: begin
        if (!any_blocked_s) begin
          if (hold_cycles_p > 0) begin
            state_next_s = HOLD;
            hold_next_s  = hold_load_lp;
          end else begin
            state_next_s = IDLE;
            enter_idle_s = 1'b1;
          end
        end else begin
          state_next_s = STALL;
        end
      end
      HOLD: begin
        if (timeout_s) begin
          state_next_s  = STALL;
          enter_stall_s = 1'b1;
        end else if (hold_r == {hold_w_lp{1'b0}}) begin
          state_next_s = IDLE;
          enter_idle_s = 1'b1;
        end else begin
          hold_next_s = hold_r - hold_w_lp'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        hold_next_s  = {hold_w_lp{1'b0}};
        enter_idle_s = 1'b1;
      end
    endcase
  end

  // Compute the next blocked mask and event count. A clear together with a STALL entry gives an event count of 1.
  always_comb begin
    mask_next_s   = mask_r;
    events_next_s = events_r;
    if (enter_stall_s) begin
      mask_next_s = at_lim_s;
    end else if (enter_idle_s) begin
      mask_next_s = {num_ports_p{1'b0}};
    end else begin
      mask_next_s = mask_r;
    end
    if (events_clear_i) begin
      events_next_s = enter_stall_s ? event_cnt_width_p'(1) : {event_cnt_width_p{1'b0}};
    end else if (enter_stall_s && (events_r != {event_cnt_width_p{1'b1}})) begin
      events_next_s = events_r + event_cnt_width_p'(1);
    end else begin
      events_next_s = events_r;
    end
  end

  // State, counter, mask and event registers, with asynchronous reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      hold_r   <= {hold_w_lp{1'b0}};
      cnt_r    <= {(num_ports_p*lg_lim_lp){1'b0}};
      mask_r   <= {num_ports_p{1'b0}};
      events_r <= {event_cnt_width_p{1'b0}};
    end else begin
      state_r  <= state_next_s;
      hold_r   <= hold_next_s;
      cnt_r    <= cnt_next_s;
      mask_r   <= mask_next_s;
      events_r <= events_next_s;
    end
  end

  assign timeout_o        = timeout_s;
  assign blocked_mask_o   = mask_r;
  assign timeout_events_o = events_r;
  assign cache_req_busy_o = credits_full_i | ~cmd_ready_i | ~req_ready_i | timeout_s | (state_r != IDLE);

endmodule

// File: tb/tb_bp_lce_busy_ctrl.sv
// tb_bp_lce_busy_ctrl
// -------------------
// Directed bench for bp_lce_busy_ctrl. Two instances share the same inputs:
//   a: hold 2 cycles, 16-bit event counter
//   b: hold 0 cycles, 4-bit event counter (used to observe saturation)
// A behavioural model tracks the stall episode of each instance. It is compared
// on every falling edge, and hand-computed literal checks pin key cycles.
module tb_bp_lce_busy_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] pkt_v = 3'b000;
  logic [2:0] pkt_yumi = 3'b000;
  logic       per_port_mode = 1'b1;
  logic [2:0] timeout_limit = 3'd4;
  logic       credits_full = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       req_ready = 1'b1;
  logic       events_clear = 1'b0;

  logic        busy_a, timeout_a;
  logic [2:0]  mask_a;
  logic [15:0] events_a;
  logic        busy_b, timeout_b;
  logic [2:0]  mask_b;
  logic [3:0]  events_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bp_lce_busy_ctrl #(.num_ports_p(3), .timeout_max_limit_p(4), .hold_cycles_p(2), .event_cnt_width_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .pkt_v_i(pkt_v), .pkt_yumi_i(pkt_yumi),
    .per_port_mode_i(per_port_mode), .timeout_limit_i(timeout_limit),
    .credits_full_i(credits_full), .cmd_ready_i(cmd_ready), .req_ready_i(req_ready),
    .events_clear_i(events_clear), .cache_req_busy_o(busy_a), .timeout_o(timeout_a),
    .blocked_mask_o(mask_a), .timeout_events_o(events_a));

  bp_lce_busy_ctrl #(.num_ports_p(3), .timeout_max_limit_p(4), .hold_cycles_p(0), .event_cnt_width_p(4)) dut_h0 (
    .clk_i(clk), .reset_n_i(reset_n), .pkt_v_i(pkt_v), .pkt_yumi_i(pkt_yumi),
    .per_port_mode_i(per_port_mode), .timeout_limit_i(timeout_limit),
    .credits_full_i(credits_full), .cmd_ready_i(cmd_ready), .req_ready_i(req_ready),
    .events_clear_i(events_clear), .cache_req_busy_o(busy_b), .timeout_o(timeout_b),
    .blocked_mask_o(mask_b), .timeout_events_o(events_b));

  // Model state per instance. phase: 0 idle, 1 stalled, 2 post-stall hold window.
  int m_cnt   [2][3];
  int m_phase [2];
  int m_left  [2];
  int m_mask  [2];
  int m_ev    [2];

  function automatic int hold_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int evmax_of(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic int lim_now();
    return (int'(timeout_limit) > 4) ? 4 : int'(timeout_limit);
  endfunction

  function automatic bit m_timeout(input int k);
    int lim;
    lim = lim_now();
    if (lim == 0) return 1'b0;
    for (int i = 0; i < 3; i++) if (m_cnt[k][i] == lim) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy(input int k);
    return credits_full | !cmd_ready | !req_ready | m_timeout(k) | (m_phase[k] != 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: whole-episode behaviour per clock, reset asynchronously.
  bit   mu_to, mu_any, mu_enter, mu_leave;
  int   mu_hit, mu_lim;
  logic [2:0] mu_blk;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 3; i++) m_cnt[k][i] = 0;
        m_phase[k] = 0; m_left[k] = 0; m_mask[k] = 0; m_ev[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mu_to  = m_timeout(k);
        mu_lim = lim_now();
        mu_hit = 0;
        for (int i = 0; i < 3; i++) if (m_cnt[k][i] == mu_lim) mu_hit = mu_hit | (1 << i);
        mu_blk = pkt_v & ~pkt_yumi;
        mu_any = (mu_blk != 3'b000);
        mu_enter = 1'b0;
        mu_leave = 1'b0;
        if (m_phase[k] == 0) begin
          mu_enter = mu_to;
        end else if (m_phase[k] == 1) begin
          if (!mu_any) begin
            if (hold_of(k) > 0) begin
              m_phase[k] = 2;
              m_left[k]  = hold_of(k);
            end else begin
              mu_leave = 1'b1;
            end
          end
        end else begin
          if (mu_to) mu_enter = 1'b1;
          else begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) mu_leave = 1'b1;
          end
        end
        if (mu_enter) m_phase[k] = 1;
        if (mu_leave) m_phase[k] = 0;
        if (mu_enter) m_mask[k] = mu_hit;
        else if (mu_leave) m_mask[k] = 0;
        if (events_clear) m_ev[k] = mu_enter ? 1 : 0;
        else if (mu_enter && m_ev[k] < evmax_of(k)) m_ev[k] = m_ev[k] + 1;
        for (int i = 0; i < 3; i++) begin
          if (per_port_mode) m_cnt[k][i] = mu_blk[i] ? ((m_cnt[k][i] >= 4) ? 4 : m_cnt[k][i] + 1) : 0;
          else if (i == 0) m_cnt[k][i] = mu_any ? ((m_cnt[k][i] >= 4) ? 4 : m_cnt[k][i] + 1) : 0;
          else m_cnt[k][i] = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_busy_a",    32'(busy_a),    32'(m_busy(0)));
      chk("cmp_timeout_a", 32'(timeout_a), 32'(m_timeout(0)));
      chk("cmp_mask_a",    32'(mask_a),    32'(m_mask[0]));
      chk("cmp_events_a",  32'(events_a),  32'(m_ev[0]));
      chk("cmp_busy_b",    32'(busy_b),    32'(m_busy(1)));
      chk("cmp_timeout_b", 32'(timeout_b), 32'(m_timeout(1)));
      chk("cmp_mask_b",    32'(mask_b),    32'(m_mask[1]));
      chk("cmp_events_b",  32'(events_b),  32'(m_ev[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    #2;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_events", 32'(events_a), 32'd0);
    credits_full = 1'b1;
    #1 chk("rst_busy_credits", 32'(busy_a), 32'd1);
    credits_full = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Test 1: per-port, lim 4, port 1 blocked from cycle 0, yumi in cycle 9
    tick(); pkt_v = 3'b010;                                   // cycle 0
    repeat (3) tick();                                        // cycle 3
    #2 chk("t1_to_c3", 32'(timeout_a), 32'd0);
    tick(); #2 chk("t1_to_c4", 32'(timeout_a), 32'd1);
    chk("t1_busy_c4", 32'(busy_a), 32'd1);
    tick(); #2 chk("t1_mask_c5", 32'(mask_a), 32'd2);         // cycle 5
    chk("t1_ev_c5", 32'(events_a), 32'd1);
    repeat (4) tick(); pkt_yumi = 3'b010;                     // cycle 9
    tick(); pkt_v = 3'b000; pkt_yumi = 3'b000;                // cycle 10
    #2 chk("t1_busy_c10", 32'(busy_a), 32'd1);
    chk("t1_busy_b_c10", 32'(busy_b), 32'd0);
    tick(); #2 chk("t1_busy_c11", 32'(busy_a), 32'd1);
    tick(); #2 chk("t1_busy_c12", 32'(busy_a), 32'd0);
    chk("t1_mask_c12", 32'(mask_a), 32'd0);

    // Test 2: aggregate mode, alternating ports 0 and 2, lim 3
    per_port_mode = 1'b0; timeout_limit = 3'd3;
    repeat (3) tick();
    tick(); pkt_v = 3'b001;                                   // cycle 0
    tick(); pkt_v = 3'b100;                                   // cycle 1
    tick(); pkt_v = 3'b001;                                   // cycle 2
    #2 chk("t2_to_c2", 32'(timeout_a), 32'd0);
    tick(); pkt_v = 3'b100;                                   // cycle 3
    #2 chk("t2_to_c3", 32'(timeout_a), 32'd1);
    tick(); pkt_v = 3'b000;
    repeat (6) tick();
    per_port_mode = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick(); pkt_v = (i % 2 == 1) ? 3'b100 : 3'b001;
      #2 chk("t2_pp_no_to", 32'(timeout_a), 32'd0);
    end
    tick(); pkt_v = 3'b000;
    repeat (3) tick();

    // Test 3: lim 0, port 0 blocked for 20 cycles, busy only from the side inputs
    timeout_limit = 3'd0;
    tick(); pkt_v = 3'b001;
    for (int i = 0; i < 20; i++) begin
      tick();
      credits_full = (i % 5 == 1);
      cmd_ready    = (i % 7 != 3);
      req_ready    = (i % 6 != 4);
      #2 chk("t3_busy", 32'(busy_a), 32'(credits_full | !cmd_ready | !req_ready));
      chk("t3_to", 32'(timeout_a), 32'd0);
    end
    credits_full = 1'b0; cmd_ready = 1'b1; req_ready = 1'b1;
    timeout_limit = 3'd7;                                     // clamps to 4, counter already at 4
    #1 chk("t3_clamp_to", 32'(timeout_a), 32'd1);
    tick(); pkt_v = 3'b000;
    repeat (5) tick();

    // Test 4: re-block during HOLD reaches the limit and re-enters STALL
    tick(); events_clear = 1'b1;
    tick(); events_clear = 1'b0;
    #2 chk("t4_ev_clr", 32'(events_a), 32'd0);
    timeout_limit = 3'd1;
    tick(); pkt_v = 3'b001;                                   // cycle 0
    tick();                                                   // cycle 1 timeout
    tick();                                                   // cycle 2 STALL
    tick(); pkt_yumi = 3'b001;                                // cycle 3
    tick(); pkt_v = 3'b100; pkt_yumi = 3'b000;                // cycle 4 HOLD
    #2 chk("t4_mask_hold", 32'(mask_a), 32'd1);
    tick(); #2 chk("t4_to_hold", 32'(timeout_a), 32'd1);      // cycle 5
    tick(); #2 chk("t4_mask_reload", 32'(mask_a), 32'd4);     // cycle 6
    chk("t4_ev2", 32'(events_a), 32'd2);
    pkt_v = 3'b000;
    repeat (6) tick();

    // Test 5: clear coinciding with STALL entry, then saturation of the 4-bit counter
    tick(); pkt_v = 3'b001;                                   // cycle 0
    tick(); pkt_v = 3'b000; events_clear = 1'b1;              // cycle 1, entry
    tick(); events_clear = 1'b0;
    #2 chk("t5_clr_entry_a", 32'(events_a), 32'd1);
    chk("t5_clr_entry_b", 32'(events_b), 32'd1);
    repeat (5) tick();
    for (int n = 0; n < 18; n++) begin
      tick(); pkt_v = 3'b001;
      tick(); pkt_v = 3'b000;
      repeat (4) tick();
    end
    #2 chk("t5_sat_b", 32'(events_b), 32'd15);
    chk("t5_ev_a", 32'(events_a), 32'd19);

    // Test 6: asynchronous reset mid-STALL
    timeout_limit = 3'd2;
    tick(); pkt_v = 3'b010;                                   // cycle 0
    repeat (4) tick();                                        // cycle 4, STALL
    #1 chk("t6_busy_pre", 32'(busy_a), 32'd1);
    reset_n = 1'b0; credits_full = 1'b1;
    #1 chk("t6_to", 32'(timeout_a), 32'd0);
    chk("t6_mask", 32'(mask_a), 32'd0);
    chk("t6_ev", 32'(events_a), 32'd0);
    chk("t6_busy_credits", 32'(busy_a), 32'd1);
    credits_full = 1'b0;
    #1 chk("t6_busy", 32'(busy_a), 32'd0);
    tick(); reset_n = 1'b1; pkt_v = 3'b000;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
